// File: rtl/seq_detector.sv
// seq_detector: pattern detector and frame-lock tracker for a serial bit stream.
//
// Samples din on clock edges where en=1. It flags every occurrence of a
// PAT_W-bit pattern, and overlapping occurrences count. It declares frame lock
// after LOCK_N matches that are spaced exactly PAT_W valid bits apart.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         bit-valid qualifier for din
//   din        serial data bit
//   clr        synchronous flush; also latches pat into the pattern register
//   pat        pattern, pat[0] is the first bit in time
//   match      one-cycle pulse when the last PAT_W valid bits equal the pattern
//   match_cnt  saturating count of match pulses
//   locked     high while in LOCKED
//   state      FSM state: 0 HUNT, 1 VERIFY, 2 LOCKED
//   err_cnt    (SEQ_DET_ERR_EN) saturating count of on-period misses
//   lost       (SEQ_DET_ERR_EN) one-cycle pulse on each LOCKED->HUNT transition
//
// Optional feature macro: SEQ_DET_ERR_EN
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | searching for any occurrence of the pattern
// VERIFY  | pattern seen; counting matches that repeat every PAT_W bits
// LOCKED  | frame lock held; drops after MISS_N consecutive on-period misses
//
// PAT_W must be at least 2.

module seq_detector #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter int               LOCK_N  = 3,
  parameter int               MISS_N  = 2,
  parameter logic [0:PAT_W-1] PAT_RST = 4'b1001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  input  logic [0:PAT_W-1] pat,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             locked,
  output logic [1:0]       state
`ifdef SEQ_DET_ERR_EN
  ,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lost
`endif
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int PH_W   = $clog2(PAT_W);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // r_win[0] holds the newest bit, so the oldest bit sits in the MSB.
  logic [PAT_W-1:0]  r_win;
  logic [FILL_W-1:0] r_fill;
  logic [PH_W-1:0]   r_ph;
  logic [3:0]        r_hit;
  logic [3:0]        r_miss;
  logic [0:PAT_W-1]  r_pat;
  logic              r_match;
  logic [CNT_W-1:0]  r_match_cnt;
  state_t            r_state;

  logic [PAT_W-1:0]  w_win_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PH_W-1:0]   w_ph_nxt;
  logic [3:0]        w_hit_nxt;
  logic [3:0]        w_miss_nxt;
  logic              w_match_nxt;
  logic [CNT_W-1:0]  w_match_cnt_nxt;
  state_t            w_state_nxt;
  logic              w_hit_now;
  logic              w_expected;
  logic              w_miss_evt;
  logic              w_lost_evt;
  logic [PAT_W-1:0]  w_win_shift;
  logic [FILL_W-1:0] w_fill_inc;

  // Both vectors are packed with the oldest bit leftmost. The compare is a
  // plain equality in time order.
  assign w_win_shift = {r_win[PAT_W-2:0], din};
  assign w_fill_inc  = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
  assign w_hit_now   = (w_win_shift == r_pat) && (w_fill_inc == FILL_W'(PAT_W));
  assign w_expected  = (r_ph == PH_W'(PAT_W - 1));

  always_comb begin
    w_win_nxt       = r_win;
    w_fill_nxt      = r_fill;
    w_ph_nxt        = r_ph;
    w_hit_nxt       = r_hit;
    w_miss_nxt      = r_miss;
    w_match_nxt     = 1'b0;
    w_match_cnt_nxt = r_match_cnt;
    w_state_nxt     = r_state;
    w_miss_evt      = 1'b0;
    w_lost_evt      = 1'b0;

    if (en) begin
      w_win_nxt   = w_win_shift;
      w_fill_nxt  = w_fill_inc;
      w_match_nxt = w_hit_now;
      if (w_hit_now && (r_match_cnt != {CNT_W{1'b1}}))
        w_match_cnt_nxt = r_match_cnt + 1'b1;

      case (r_state)
        ST_HUNT: begin
          if (w_hit_now) begin
            w_hit_nxt   = 4'd1;
            w_miss_nxt  = 4'd0;
            w_ph_nxt    = '0;
            w_state_nxt = (LOCK_N <= 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_expected) begin
            w_ph_nxt = '0;
            if (w_hit_now) begin
              w_hit_nxt = r_hit + 4'd1;
              if ((int'(r_hit) + 1) >= LOCK_N) begin
                w_state_nxt = ST_LOCKED;
                w_miss_nxt  = 4'd0;
              end
            end else begin
              w_miss_evt  = 1'b1;
              w_hit_nxt   = 4'd0;
              w_state_nxt = ST_HUNT;
            end
          end else begin
            // Off-period hits (self-overlapping patterns) pulse match only.
            w_ph_nxt = r_ph + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_expected) begin
            w_ph_nxt = '0;
            if (w_hit_now) begin
              w_miss_nxt = 4'd0;
            end else begin
              w_miss_evt = 1'b1;
              if ((int'(r_miss) + 1) >= MISS_N) begin
                w_lost_evt  = 1'b1;
                w_hit_nxt   = 4'd0;
                w_miss_nxt  = 4'd0;
                w_state_nxt = ST_HUNT;
              end else begin
                w_miss_nxt = r_miss + 4'd1;
              end
            end
          end else begin
            w_ph_nxt = r_ph + 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_fill      <= '0;
      r_ph        <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_pat       <= PAT_RST;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
      r_state     <= ST_HUNT;
    end else if (clr) begin
      r_win       <= '0;
      r_fill      <= '0;
      r_ph        <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_pat       <= pat;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
      r_state     <= ST_HUNT;
    end else begin
      r_win       <= w_win_nxt;
      r_fill      <= w_fill_nxt;
      r_ph        <= w_ph_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_match     <= w_match_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_state     <= w_state_nxt;
    end
  end

  assign match     = r_match;
  assign match_cnt = r_match_cnt;
  assign locked    = (r_state == ST_LOCKED);
  assign state     = r_state;

`ifdef SEQ_DET_ERR_EN
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_lost    <= 1'b0;
    end else if (clr) begin
      r_err_cnt <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_lost <= w_lost_evt;
      if (w_miss_evt && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
  assign lost    = r_lost;
`endif

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;
  localparam int PAT_W  = 4;
  localparam int LOCK_N = 3;
  localparam int MISS_N = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic             din   = 1'b0;
  logic             clr   = 1'b0;
  logic [0:PAT_W-1] pat   = 4'b1001;

  logic       match,   locked;
  logic [7:0] match_cnt;
  logic [1:0] state;
  logic       match_s, locked_s;
  logic [2:0] match_cnt_s;
  logic [1:0] state_s;
`ifdef SEQ_DET_ERR_EN
  logic [7:0] err_cnt;
  logic       lost;
  logic [2:0] err_cnt_s;
  logic       lost_s;
  int         lost_seen = 0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_detector #(.PAT_W(PAT_W), .CNT_W(8), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr), .pat(pat),
    .match(match), .match_cnt(match_cnt), .locked(locked), .state(state)
`ifdef SEQ_DET_ERR_EN
    , .err_cnt(err_cnt), .lost(lost)
`endif
  );

  seq_detector #(.PAT_W(PAT_W), .CNT_W(3), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr), .pat(pat),
    .match(match_s), .match_cnt(match_cnt_s), .locked(locked_s), .state(state_s)
`ifdef SEQ_DET_ERR_EN
    , .err_cnt(err_cnt_s), .lost(lost_s)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: keeps the valid-bit history and the index of the last
  // on-period match, so period tracking is plain arithmetic on bit indices.
  bit               hist[$];
  int               nvalid = 0, anchor = 0, mode = 0, hits = 0, misses = 0;
  bit [0:PAT_W-1]   m_pat  = 4'b1001;
  int               e_match = 0, e_cnt = 0, e_cnt_s = 0, e_err = 0, e_err_s = 0, e_lost = 0;

  task model_clear();
    hist.delete();
    nvalid = 0; anchor = 0; mode = 0; hits = 0; misses = 0;
    e_match = 0; e_cnt = 0; e_cnt_s = 0; e_err = 0; e_err_s = 0; e_lost = 0;
  endtask

  task model_miss();
    if (e_err < 255) e_err++;
    if (e_err_s < 7) e_err_s++;
  endtask

  task model_step(input bit d);
    bit h, on;
    hist.push_back(d);
    if (hist.size() > PAT_W) void'(hist.pop_front());
    nvalid++;
    h = (hist.size() == PAT_W);
    for (int i = 0; i < PAT_W; i++) if (h && hist[i] != m_pat[i]) h = 0;
    e_match = h;
    e_lost  = 0;
    if (h) begin
      if (e_cnt < 255) e_cnt++;
      if (e_cnt_s < 7) e_cnt_s++;
    end
    on = ((nvalid - anchor) == PAT_W);
    if (mode == 0) begin
      if (h) begin
        hits = 1; misses = 0; anchor = nvalid;
        mode = (LOCK_N == 1) ? 2 : 1;
      end
    end else if (mode == 1) begin
      if (on) begin
        if (h) begin
          hits++; anchor = nvalid;
          if (hits >= LOCK_N) begin mode = 2; misses = 0; end
        end else begin
          model_miss(); mode = 0; hits = 0;
        end
      end
    end else if (on) begin
      anchor = nvalid;
      if (h) misses = 0;
      else begin
        model_miss(); misses++;
        if (misses >= MISS_N) begin mode = 0; hits = 0; misses = 0; e_lost = 1; end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(); m_pat = 4'b1001;
    end else if (clr) begin
      model_clear(); m_pat = pat;
    end else if (!en) begin
      e_match = 0; e_lost = 0;
    end else begin
      model_step(din);
    end
  end

  always @(negedge clk) begin
    chk("match", match, e_match);
    chk("match_cnt", match_cnt, e_cnt);
    chk("locked", locked, (mode == 2) ? 1 : 0);
    chk("state", state, mode);
    chk("match_cnt_sat", match_cnt_s, e_cnt_s);
`ifdef SEQ_DET_ERR_EN
    chk("err_cnt", err_cnt, e_err);
    chk("lost", lost, e_lost);
    chk("err_cnt_sat", err_cnt_s, e_err_s);
    if (lost) lost_seen++;
`endif
  end

  // Drives one edge's inputs and returns just after that edge.
  task automatic send(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; din = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [0:3] w);
    for (int i = 0; i < 4; i++) send(1'b1, w[i], 1'b0);
  endtask

  task automatic do_clr(input logic [0:3] p);
    pat = p;
    send(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [0:3] w;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_match", match, 0);
    chk("rst_state", state, 0);

    // Lock run; pat changes without clr must be ignored.
    do_clr(4'b1001);
    pat = 4'b0000;
    send(1, 1, 0); send(1, 0, 0); send(1, 0, 0);
    chk("no_match_bit3", match, 0);
    send(1, 1, 0);
    chk("match_bit4", match, 1);
    chk("verify_bit4", state, 1);
    send_word(4'b1001);
    chk("match_bit8", match, 1);
    send_word(4'b1001);
    chk("match_bit12", match, 1);
    chk("lock_cnt", match_cnt, 3);
    chk("lock_state", state, 2);
    send_word(4'b1101);
    chk("one_miss_locked", locked, 1);

    // Idle gaps between valid bits.
    do_clr(4'b1001);
    for (int k = 0; k < 3; k++) begin
      w = 4'b1001;
      for (int i = 0; i < 4; i++) begin
        send(1, w[i], 0);
        repeat ($urandom_range(1, 3)) send(0, 0, 0);
      end
    end
    chk("idle_cnt", match_cnt, 3);
    chk("idle_state", state, 2);

    // Two consecutive corrupted periods drop lock.
    do_clr(4'b1001);
    repeat (3) send_word(4'b1001);
`ifdef SEQ_DET_ERR_EN
    lost_seen = 0;
`endif
    send_word(4'b1101);
    send(1, 1, 0); send(1, 1, 0); send(1, 0, 0);
    chk("locked_before_2nd", locked, 1);
    send(1, 1, 0);
    chk("unlocked_after_2nd", locked, 0);
    chk("hunt_after_2nd", state, 0);
`ifdef SEQ_DET_ERR_EN
    chk("err_two_miss", err_cnt, 2);
    send(0, 0, 0);
    chk("lost_once", lost_seen, 1);
`endif

    // Self-overlapping pattern.
    do_clr(4'b1111);
    repeat (8) send(1, 1, 0);
    chk("overlap_cnt", match_cnt, 5);
    chk("overlap_state", state, 1);

    // Asynchronous reset between edges.
    send(1, 1, 0);
    chk("pre_rst_match", match, 1);
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_match", match, 0);
    chk("async_rst_cnt", match_cnt, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation, then clr with a bit presented.
    do_clr(4'b1001);
    repeat (10) send_word(4'b1001);
    chk("sat_cnt_small", match_cnt_s, 7);
    chk("sat_cnt_main", match_cnt, 10);
    send(1, 1, 1);
    chk("clr_cnt", match_cnt, 0);
    chk("clr_cnt_small", match_cnt_s, 0);
    send(1, 0, 0); send(1, 0, 0); send(1, 1, 0);
    chk("clr_discard", match, 0);
    send(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
